// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the simple_fpu datapath: rounding-mode codes,
// operand classes and width-generic builders for special encodings.
package fp_pkg;

  localparam int MAX_W = 128;
  localparam logic [MAX_W-1:0] FP_ONE = MAX_W'(1);

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RZ  = 3'd1,
    RM_RD  = 3'd2,
    RM_RU  = 3'd3,
    RM_RNA = 3'd4
  } round_mode_e;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } fp_class_e;

  function automatic int fp_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  // Magnitude builders return the encoding without the sign bit, right-aligned.
  function automatic logic [MAX_W-1:0] fp_qnan_mag(input int ew, input int mw);
    return (FP_ONE << (ew + mw)) - (FP_ONE << (mw - 1));
  endfunction

  function automatic logic [MAX_W-1:0] fp_inf_mag(input int ew, input int mw);
    return (FP_ONE << (ew + mw)) - (FP_ONE << mw);
  endfunction

  function automatic logic [MAX_W-1:0] fp_max_mag(input int ew, input int mw);
    return (FP_ONE << (ew + mw)) - FP_ONE - (FP_ONE << mw);
  endfunction

endpackage

// File: rtl/fp_round_unit.sv
// Normalises a raw significand product, applies the selected rounding mode and
// resolves overflow (mode-dependent saturation) and flush-to-zero underflow.
module fp_round_unit
  import fp_pkg::*;
#(
  parameter int EW = 8,
  parameter int MW = 23,
  localparam int W  = EW + MW + 1,
  localparam int PW = 2 * (MW + 1)
) (
  input  logic          sign,
  input  logic [EW+1:0] exp_in,
  input  logic [PW-1:0] prod,
  input  logic [2:0]    round_m,
  output logic [W-1:0]  out,
  output logic          ov,
  output logic          un,
  output logic          inexact
);

  localparam logic [W-2:0] INF_MAG = (W-1)'(fp_inf_mag(EW, MW));
  localparam logic [W-2:0] MAX_MAG = (W-1)'(fp_max_mag(EW, MW));
  localparam logic [EW:0]  EXP_SAT = (EW+1)'((1 << EW) - 1);

  logic [PW-2:0] norm;
  logic [MW-1:0] frac;
  logic          guard;
  logic          sticky;
  logic          inc;
  logic [MW:0]   rounded;
  logic [EW+1:0] exp_n;
  logic [EW+1:0] exp_r;
  logic          ovf;
  logic          unf;

  // Exponents are two's complement in EW+2 bits so both saturation ends are visible.
  always_comb begin
    norm    = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
    exp_n   = exp_in + {{(EW+1){1'b0}}, prod[PW-1]};
    frac    = norm[PW-2:MW+1];
    guard   = norm[MW];
    sticky  = |norm[MW-1:0];

    case (round_m)
      RM_RZ:   inc = 1'b0;
      RM_RU:   inc = (guard | sticky) & ~sign;
      RM_RD:   inc = (guard | sticky) & sign;
      RM_RNA:  inc = guard;
      default: inc = guard & (sticky | frac[0]);
    endcase

    rounded = {1'b0, frac} + {{MW{1'b0}}, inc};
    exp_r   = exp_n + {{(EW+1){1'b0}}, rounded[MW]};
    ovf     = ~exp_r[EW+1] & (exp_r[EW:0] >= EXP_SAT);
    unf     = exp_r[EW+1] | (exp_r == '0);

    out     = {sign, exp_r[EW-1:0], rounded[MW-1:0]};
    ov      = 1'b0;
    un      = 1'b0;
    inexact = guard | sticky;

    if (ovf) begin
      ov      = 1'b1;
      inexact = 1'b1;
      case (round_m)
        RM_RZ:   out = {sign, MAX_MAG};
        RM_RU:   out = sign ? {1'b1, MAX_MAG} : {1'b0, INF_MAG};
        RM_RD:   out = sign ? {1'b1, INF_MAG} : {1'b0, MAX_MAG};
        default: out = {sign, INF_MAG};
      endcase
    end else if (unf) begin
      un      = 1'b1;
      inexact = 1'b1;
      out     = {sign, {(W-1){1'b0}}};
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 multiplier (classify, multiply, round) with valid/ready flow
// control; subnormal inputs read as zero and tiny results flush to zero.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EW = 8,
  parameter int MW = 23,
  localparam int W = EW + MW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [2:0]   round_m,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         ov,
  output logic         un,
  output logic         inv,
  output logic         inexact
);

  localparam int PW   = 2 * (MW + 1);
  localparam int BIAS = fp_bias(EW);
  localparam logic [W-2:0] QNAN_MAG = (W-1)'(fp_qnan_mag(EW, MW));
  localparam logic [W-2:0] INF_MAG  = (W-1)'(fp_inf_mag(EW, MW));

  function automatic fp_class_e classify(input logic [W-2:0] x);
    if (x[W-2:MW] == '0) return CLS_ZERO;
    if (x[W-2:MW] != '1) return CLS_NORM;
    if (x[MW-1:0] == '0) return CLS_INF;
    return x[MW-1] ? CLS_QNAN : CLS_SNAN;
  endfunction

  logic stall;

  fp_class_e    c1;
  fp_class_e    c2;
  logic         sign_n;
  logic         sp_hit;
  logic         sp_inv;
  logic [W-1:0] sp_res;

  logic          s1_valid;
  logic          s1_sign;
  logic [EW-1:0] s1_exp1;
  logic [EW-1:0] s1_exp2;
  logic [MW:0]   s1_m1;
  logic [MW:0]   s1_m2;
  logic [2:0]    s1_rm;
  logic          s1_special;
  logic          s1_sp_inv;
  logic [W-1:0]  s1_sp_res;

  logic          s2_valid;
  logic          s2_sign;
  logic [EW+1:0] s2_exp;
  logic [PW-1:0] s2_prod;
  logic [2:0]    s2_rm;
  logic          s2_special;
  logic          s2_sp_inv;
  logic [W-1:0]  s2_sp_res;

  logic [W-1:0]  r_out;
  logic          r_ov;
  logic          r_un;
  logic          r_inexact;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Special operands are resolved up front and bypass the arithmetic stages.
  always_comb begin
    c1     = classify(in1[W-2:0]);
    c2     = classify(in2[W-2:0]);
    sign_n = in1[W-1] ^ in2[W-1];
    sp_hit = 1'b1;
    sp_inv = 1'b0;
    sp_res = {1'b0, QNAN_MAG};
    if ((c1 inside {CLS_QNAN, CLS_SNAN}) || (c2 inside {CLS_QNAN, CLS_SNAN})) begin
      sp_inv = (c1 == CLS_SNAN) || (c2 == CLS_SNAN);
    end else if ((c1 == CLS_INF && c2 == CLS_ZERO) || (c1 == CLS_ZERO && c2 == CLS_INF)) begin
      sp_inv = 1'b1;
    end else if (c1 == CLS_INF || c2 == CLS_INF) begin
      sp_res = {sign_n, INF_MAG};
    end else if (c1 == CLS_ZERO || c2 == CLS_ZERO) begin
      sp_res = {sign_n, {(W-1){1'b0}}};
    end else begin
      sp_hit = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_exp1    <= '0;
      s1_exp2    <= '0;
      s1_m1      <= '0;
      s1_m2      <= '0;
      s1_rm      <= '0;
      s1_special <= 1'b0;
      s1_sp_inv  <= 1'b0;
      s1_sp_res  <= '0;
    end else if (!stall) begin
      s1_valid   <= in_valid;
      s1_sign    <= sign_n;
      s1_exp1    <= in1[W-2:MW];
      s1_exp2    <= in2[W-2:MW];
      s1_m1      <= {1'b1, in1[MW-1:0]};
      s1_m2      <= {1'b1, in2[MW-1:0]};
      s1_rm      <= round_m;
      s1_special <= sp_hit;
      s1_sp_inv  <= sp_inv;
      s1_sp_res  <= sp_res;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_valid   <= 1'b0;
      s2_sign    <= 1'b0;
      s2_exp     <= '0;
      s2_prod    <= '0;
      s2_rm      <= '0;
      s2_special <= 1'b0;
      s2_sp_inv  <= 1'b0;
      s2_sp_res  <= '0;
    end else if (!stall) begin
      s2_valid   <= s1_valid;
      s2_sign    <= s1_sign;
      s2_exp     <= {2'b00, s1_exp1} + {2'b00, s1_exp2} - (EW+2)'(BIAS);
      s2_prod    <= PW'(s1_m1) * PW'(s1_m2);
      s2_rm      <= s1_rm;
      s2_special <= s1_special;
      s2_sp_inv  <= s1_sp_inv;
      s2_sp_res  <= s1_sp_res;
    end
  end

  fp_round_unit #(
    .EW (EW),
    .MW (MW)
  ) u_round (
    .sign    (s2_sign),
    .exp_in  (s2_exp),
    .prod    (s2_prod),
    .round_m (s2_rm),
    .out     (r_out),
    .ov      (r_ov),
    .un      (r_un),
    .inexact (r_inexact)
  );

  // Bubbles clear the flags but leave the last result on out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      ov        <= 1'b0;
      un        <= 1'b0;
      inv       <= 1'b0;
      inexact   <= 1'b0;
    end else if (!stall) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out     <= s2_special ? s2_sp_res : r_out;
        ov      <= ~s2_special & r_ov;
        un      <= ~s2_special & r_un;
        inv     <= s2_special & s2_sp_inv;
        inexact <= ~s2_special & r_inexact;
      end else begin
        ov      <= 1'b0;
        un      <= 1'b0;
        inv     <= 1'b0;
        inexact <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe: single-precision instance for most scenarios plus a
// double-precision instance; flags are compared as {ov,un,inv,inexact}.
`timescale 1ns/1ps
module tb_fp_mul_pipe;
  import fp_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in1, in2, out;
  logic [2:0]  round_m;
  logic        ov, un, inv, inexact;

  logic        d_in_valid, d_in_ready, d_out_valid;
  logic        d_out_ready = 1'b1;
  logic [63:0] d_in1, d_in2, d_out;
  logic        d_ov, d_un, d_inv, d_inexact;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [63:0] dsb[$];

  always #5 clk = ~clk;

  fp_mul_pipe #(.EW(8), .MW(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .round_m(round_m), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .ov(ov), .un(un), .inv(inv), .inexact(inexact)
  );

  fp_mul_pipe #(.EW(11), .MW(52)) dut_d (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in1(d_in1), .in2(d_in2), .round_m(RM_RNE), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .out(d_out), .ov(d_ov), .un(d_un), .inv(d_inv), .inexact(d_inexact)
  );

  // Issues one operation and waits for its result; lat counts edges from accept to out_valid.
  task automatic run_single(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                            output logic [31:0] obs, output logic [3:0] fl, output int lat);
    in1 = a;
    in2 = b;
    round_m = rm;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    obs = out;
    fl = {ov, un, inv, inexact};
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in1 = '0;
    in2 = '0;
    round_m = RM_RNE;
    d_in_valid = 1'b0;
    d_in1 = '0;
    d_in2 = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (out !== 32'h0) begin errors++; $display("[TB] FAIL reset_out: got %h expected 00000000", out); end
    checks++;
    if ({ov, un, inv, inexact} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {ov, un, inv, inexact}); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (d_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_d_out_valid: got %b expected 0", d_out_valid); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_latency();
    logic [31:0] obs;
    logic [3:0]  fl;
    int lat;
    exp_t e;
    e.res = 32'h40400000;
    e.flags = 4'b0000;
    sb.push_back(e);
    run_single(32'h3FC00000, 32'h40000000, RM_RNE, obs, fl, lat);
    e = sb.pop_front();
    checks++;
    if (lat != 3) begin errors++; $display("[TB] FAIL latency: got %0d expected 3", lat); end
    checks++;
    if (obs !== e.res) begin errors++; $display("[TB] FAIL latency_result: got %h expected %h", obs, e.res); end
    checks++;
    if (fl !== e.flags) begin errors++; $display("[TB] FAIL latency_flags: got %b expected %b", fl, e.flags); end
  endtask

  task automatic test_rounding();
    logic [2:0]  rm_t  [5] = '{RM_RNE, RM_RZ, RM_RNA, RM_RU, RM_RD};
    logic [31:0] res_t [5] = '{32'h3FC00002, 32'h3FC00001, 32'h3FC00002, 32'h3FC00002, 32'h3FC00001};
    logic [31:0] obs;
    logic [3:0]  fl;
    int lat;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      e.res = res_t[i];
      e.flags = 4'b0001;
      sb.push_back(e);
      run_single(32'h3F800001, 32'h3FC00000, rm_t[i], obs, fl, lat);
      e = sb.pop_front();
      checks++;
      if (obs !== e.res) begin errors++; $display("[TB] FAIL round_%0d: got %h expected %h", i, obs, e.res); end
      checks++;
      if (fl !== e.flags) begin errors++; $display("[TB] FAIL round_flags_%0d: got %b expected %b", i, fl, e.flags); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] a_t   [4] = '{32'h7F000000, 32'h7F000000, 32'hFF000000, 32'hFF000000};
    logic [2:0]  rm_t  [4] = '{RM_RNE, RM_RZ, RM_RD, RM_RU};
    logic [31:0] res_t [4] = '{32'h7F800000, 32'h7F7FFFFF, 32'hFF800000, 32'hFF7FFFFF};
    logic [31:0] obs;
    logic [3:0]  fl;
    int lat;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.res = res_t[i];
      e.flags = 4'b1001;
      sb.push_back(e);
      run_single(a_t[i], 32'h40000000, rm_t[i], obs, fl, lat);
      e = sb.pop_front();
      checks++;
      if (obs !== e.res) begin errors++; $display("[TB] FAIL overflow_%0d: got %h expected %h", i, obs, e.res); end
      checks++;
      if (fl !== e.flags) begin errors++; $display("[TB] FAIL overflow_flags_%0d: got %b expected %b", i, fl, e.flags); end
    end
  endtask

  task automatic test_specials();
    logic [31:0] a_t   [7] = '{32'h7F800000, 32'h7F800001, 32'h00800000, 32'h7FC00000,
                               32'h7F800000, 32'h00000000, 32'h00000001};
    logic [31:0] b_t   [7] = '{32'h80000000, 32'h3F800000, 32'h00800000, 32'h3F800000,
                               32'hC0000000, 32'hBF800000, 32'h3F800000};
    logic [31:0] res_t [7] = '{32'h7FC00000, 32'h7FC00000, 32'h00000000, 32'h7FC00000,
                               32'hFF800000, 32'h80000000, 32'h00000000};
    logic [3:0]  fl_t  [7] = '{4'b0010, 4'b0010, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [31:0] obs;
    logic [3:0]  fl;
    int lat;
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      e.res = res_t[i];
      e.flags = fl_t[i];
      sb.push_back(e);
      run_single(a_t[i], b_t[i], RM_RNE, obs, fl, lat);
      e = sb.pop_front();
      checks++;
      if (obs !== e.res) begin errors++; $display("[TB] FAIL special_%0d: got %h expected %h", i, obs, e.res); end
      checks++;
      if (fl !== e.flags) begin errors++; $display("[TB] FAIL special_flags_%0d: got %b expected %b", i, fl, e.flags); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_t   [4] = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'hC0000000};
    logic [31:0] b_t   [4] = '{32'h3F800000, 32'h40400000, 32'h3FC00000, 32'h3F000000};
    logic [31:0] res_t [4] = '{32'h3F800000, 32'h40C00000, 32'h40100000, 32'hBF800000};
    int got = 0;
    int stalls = 0;
    int unstable = 0;
    int extra = 0;
    bit holding = 1'b0;
    logic [31:0] held = '0;
    exp_t e;
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          in1 = a_t[i];
          in2 = b_t[i];
          round_m = RM_RNE;
          in_valid = 1'b1;
          #1;
          for (int w = 0; w < 20 && !in_ready; w++) begin
            @(negedge clk);
            #1;
          end
          e.res = res_t[i];
          e.flags = 4'b0000;
          sb.push_back(e);
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
      begin
        for (int c = 0; c < 40 && got < 4; c++) begin
          @(negedge clk);
          #1;
          if (out_valid && !out_ready) begin
            if (!in_ready) stalls++;
            if (holding && out !== held) unstable++;
            held = out;
            holding = 1'b1;
          end else begin
            holding = 1'b0;
          end
          if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("[TB] FAIL b2b_extra_result: got %h expected none", out);
            end else begin
              e = sb.pop_front();
              if (out !== e.res || {ov, un, inv, inexact} !== e.flags) begin
                errors++;
                $display("[TB] FAIL b2b_result_%0d: got %h/%b expected %h/%b", got, out, {ov, un, inv, inexact}, e.res, e.flags);
              end
            end
            got++;
          end
        end
      end
    join
    repeat (4) begin
      @(negedge clk);
      #1;
      if (out_valid) extra++;
    end
    checks++;
    if (got != 4) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 4", got); end
    checks++;
    if (stalls == 0) begin errors++; $display("[TB] FAIL b2b_in_ready_drop: got %0d stalled cycles expected >0", stalls); end
    checks++;
    if (unstable != 0) begin errors++; $display("[TB] FAIL b2b_hold_stable: got %0d changes expected 0", unstable); end
    checks++;
    if (extra != 0 || sb.size() != 0) begin errors++; $display("[TB] FAIL b2b_duplicate: got %0d extra, %0d pending expected 0", extra, sb.size()); end
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    @(negedge clk);
    out_ready = 1'b1;
    round_m = RM_RNE;
    in1 = 32'h3F800000;
    in2 = 32'h40000000;
    in_valid = 1'b1;
    @(negedge clk);
    in2 = 32'h40400000;
    @(negedge clk);
    in2 = 32'h40800000;
    rst = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_out_valid: got %b expected 0", out_valid); end
    repeat (8) begin
      @(negedge clk);
      #1;
      if (out_valid) stale++;
    end
    checks++;
    if (stale != 0) begin errors++; $display("[TB] FAIL midreset_stale: got %0d results expected 0", stale); end
  endtask

  task automatic test_double();
    logic [63:0] expv;
    int w = 0;
    dsb.push_back(64'h4008000000000000);
    d_in1 = 64'h3FF8000000000000;
    d_in2 = 64'h4000000000000000;
    d_in_valid = 1'b1;
    #1;
    while (!d_in_ready && w < 10) begin @(negedge clk); #1; w++; end
    @(posedge clk);
    @(negedge clk);
    d_in_valid = 1'b0;
    #1;
    w = 0;
    while (!d_out_valid && w < 10) begin @(negedge clk); #1; w++; end
    expv = dsb.pop_front();
    checks++;
    if (d_out !== expv) begin errors++; $display("[TB] FAIL double_result: got %h expected %h", d_out, expv); end
    checks++;
    if ({d_ov, d_un, d_inv, d_inexact} !== 4'b0000) begin errors++; $display("[TB] FAIL double_flags: got %b expected 0000", {d_ov, d_un, d_inv, d_inexact}); end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_rounding();
    test_overflow();
    test_specials();
    test_back_to_back();
    test_reset_midflight();
    test_double();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
